sl_transmitter: RTL and testbench
=================================

Name: sl_transmitter

Overview:
- Register-programmed serial transmitter for the two-wire SL line (SL0/SL1).
- Host writes a config register (word length, bit-rate mode), then a data word; block serializes data MSB-first plus odd parity, then a stop condition.
- Busy status is readable; sits between a simple register bus and the SL line drivers.

Parameters:
- MAX_LEN, 32, maximum data bits per word (also data register width).
- BASE_DIV, 4, clock cycles per half-bit at frequency mode 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- d_in  in  32  register write data.
- wr_en  in  1  write strobe, one clk per write.
- addr  in  1  register select: 0 = DATA, 1 = CONFIG/STATUS.
- d_out  out  32  combinational read of the register selected by addr.
- SL0  out  1  line 0; idle high; low pulse = data/parity bit '0'.
- SL1  out  1  line 1; idle high; low pulse = data/parity bit '1'.

Behaviour:
- Reset values:
  - SL0=SL1=1; busy=0.
  - CONFIG: len=32, freq=0; DATA register=0.
  - FSM in IDLE; d_out follows addr from the reset values.
- CONFIG write (addr=1, wr_en=1), fields from d_in:
  - len = d_in[5:0]; values >32 clamp to 32.
  - d_in[6] reserved, ignored.
  - freq = d_in[9:7]; 6 and 7 act as 5.
  - Ignored while busy.
- DATA write (addr=0, wr_en=1) in IDLE:
  - Latch d_in[len-1:0]; bits above len are ignored.
  - busy=1 from the next clk; transmission starts that same cycle.
  - Writes while busy are ignored.
  - A DATA write with len=0 is ignored; busy stays 0.
- Read map:
  - addr=0: latched DATA.
  - addr=1: {15'b0, busy at bit16, 6'b0, freq at [9:7], 1'b0, len at [5:0]}.
- Half-bit period H = BASE_DIV << freq clocks (4, 8, 16, 32, 64, 128).
- FSM IDLE -> BIT -> PARITY -> STOP -> GAP -> IDLE:
  - BIT: for each data bit, MSB (bit len-1) first, drive the matching line low for H clocks, then both high for H clocks. The other line stays high throughout.
  - PARITY: one bit encoded the same way. Value makes the total count of ones over data+parity odd.
  - STOP: SL0=SL1=0 for H clocks (word terminator).
  - GAP: both high for H clocks; busy clears on exit to IDLE.
- Both lines are never low simultaneously except in STOP.
- Total busy time = (2*len + 4)*H clocks.
- rst mid-word: lines return high immediately (next edge); word abandoned; CONFIG returns to defaults.
- Simultaneous wr_en with FSM exit from GAP: the write is ignored, since busy is still 1 that cycle.
- Outputs SL0/SL1 are registered, glitch-free.
- Receiver contract: an ideal SL receiver counts exactly len data bits, reassembles DATA, and sees valid odd parity.

Optional Feature:
- Macro SL_TX_REMAIN_CNT_EN.
- Defined: CONFIG/STATUS read adds remaining-bits count at d_out[22:17]. It equals the data+parity bits not yet started: len+1 at start, decrementing at each bit start, 0 in STOP/GAP/IDLE.
- Undefined: d_out[22:17] read as 0 and the counter logic is absent.

Decomposition:
- Package sl_pkg holds:
  - ADDR_DATA/ADDR_CFG constants.
  - CONFIG field positions (LEN_LSB=0, LEN_W=6, FREQ_LSB=7, FREQ_W=3, BUSY_BIT=16).
  - FSM state enum (IDLE, BIT, PARITY, STOP, GAP).
  - Function half_period(freq) returning H.
- One sub-module, sl_bit_timer:
  - Prescaler loaded with H.
  - Emits a one-clk phase_end tick; restarts on FSM request.

Test Plan:
- Reset: after rst, SL0=SL1=1, d_out (addr=1) = 32'h0000_0020, busy=0.
- Config len=8, freq=0, DATA=8'hA5:
  - Line shows 1,0,1,0,0,1,0,1 with 4-clk lows, then parity bit '1' on SL1 (four ones -> parity 1), then a 4-clk stop.
  - busy lasts (16+4)*4 = 80 clks.
- Config len=32, freq=5, DATA=32'hFFFF_FFFF:
  - 32 SL1 pulses of 128 clks, parity '1' (32 ones -> odd needs 1).
  - busy = 68*128 clks.
- Write DATA again while busy (len=16, DATA=16'h1234, then 16'hFFFF mid-word): only 16'h1234 is sent; CONFIG write mid-word is also ignored.
- Six random words, len = 8+2k (k in 0..12), freq 0..5:
  - Poll busy until 0 after each.
  - Receiver model word == DATA, bit count == len, parity valid.
- Assert rst halfway through a len=20 word: lines high next clk, busy=0, CONFIG back to defaults, no stop condition emitted.

Source files
------------

// File: rtl/sl_pkg.sv
// sl_pkg: shared constants, CONFIG field positions, FSM states and half-bit period helper for sl_transmitter
package sl_pkg;
  localparam int MAX_LEN = 32;
  localparam int BASE_DIV = 4;
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CFG = 1'b1;
  localparam int LEN_LSB = 0;
  localparam int LEN_W = 6;
  localparam int FREQ_LSB = 7;
  localparam int FREQ_W = 3;
  localparam int BUSY_BIT = 16;
  localparam int REM_LSB = 17;
  typedef enum logic [2:0] {IDLE, BIT, PARITY, STOP, GAP} state_e;
  function automatic logic [7:0] half_period(input logic [FREQ_W-1:0] freq);
    return 8'(BASE_DIV << freq);
  endfunction
endpackage

// File: rtl/sl_transmitter_if.sv
// sl_transmitter_if: register bus (d_in, wr_en, addr in; d_out out) with master/slave modports
interface sl_transmitter_if;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic wr_en;
  logic addr;
  modport master(output d_in, wr_en, addr, input d_out);
  modport slave(input d_in, wr_en, addr, output d_out);
endinterface

// File: rtl/sl_bit_timer.sv
// sl_bit_timer: half-bit prescaler; ports clk, rst, start_i (reload), en_i, freq_i, phase_end_o (one-clk tick every H clocks)
module sl_bit_timer
  import sl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              en_i,
  input  logic [FREQ_W-1:0] freq_i,
  output logic              phase_end_o
);
  logic [7:0] cnt_q, cnt_d, reload;
  always_comb begin
    reload = half_period(freq_i) - 8'd1;
    cnt_d = start_i ? reload : !en_i ? cnt_q : cnt_q == 8'd0 ? reload : cnt_q - 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  end
  assign phase_end_o = en_i && cnt_q == 8'd0;
endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter: SL0/SL1 serializer with register bus; ports clk, rst, bus (slave: d_in, wr_en, addr, d_out), SL0, SL1; SL_TX_REMAIN_CNT_EN adds remaining-bit count at d_out[22:17]
module sl_transmitter
  import sl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  sl_transmitter_if.slave    bus,
  output logic               SL0,
  output logic               SL1
);
  state_e state_q, state_d;
  logic half_q, half_d;
  logic [4:0] bit_q, bit_d;
  logic [31:0] data_q, data_d, mask, rd_cfg;
  logic [LEN_W-1:0] len_q, len_d, len_in;
  logic [FREQ_W-1:0] freq_q, freq_d, freq_in;
  logic sl0_q, sl0_d, sl1_q, sl1_d;
  logic busy, wr_data, wr_cfg, tick, cur_bit, low;
  assign busy = state_q != IDLE;
  assign wr_data = bus.wr_en && bus.addr == ADDR_DATA && !busy && len_q != '0;
  assign wr_cfg = bus.wr_en && bus.addr == ADDR_CFG && !busy;
  assign mask = 32'((64'd1 << len_q) - 64'd1);
  assign len_in = bus.d_in[LEN_LSB+:LEN_W] > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.d_in[LEN_LSB+:LEN_W];
  assign freq_in = bus.d_in[FREQ_LSB+:FREQ_W] > 3'd5 ? 3'd5 : bus.d_in[FREQ_LSB+:FREQ_W];
  sl_bit_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .start_i    (wr_data),
    .en_i       (busy),
    .freq_i     (freq_q),
    .phase_end_o(tick)
  );
  always_comb begin
    state_d = state_q;
    half_d = half_q;
    bit_d = bit_q;
    data_d = data_q;
    len_d = wr_cfg ? len_in : len_q;
    freq_d = wr_cfg ? freq_in : freq_q;
    if (wr_data) begin
      state_d = BIT;
      half_d = 1'b0;
      bit_d = 5'(len_q - 6'd1);
      data_d = bus.d_in & mask;
    end else if (tick) begin
      case (state_q)
        BIT: begin
          half_d = !half_q;
          if (half_q && bit_q == 5'd0) state_d = PARITY;
          else if (half_q) bit_d = bit_q - 5'd1;
        end
        PARITY: begin
          half_d = !half_q;
          if (half_q) state_d = STOP;
        end
        STOP: state_d = GAP;
        GAP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // Lines are derived from next-state values so the registered outputs change on the same edge as the FSM.
    cur_bit = state_d == PARITY ? ~^data_d : data_d[bit_d];
    low = (state_d == BIT || state_d == PARITY) && !half_d;
    sl0_d = !(state_d == STOP || (low && !cur_bit));
    sl1_d = !(state_d == STOP || (low && cur_bit));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      half_q <= 1'b0;
      bit_q <= 5'd0;
      data_q <= 32'd0;
      len_q <= LEN_W'(MAX_LEN);
      freq_q <= '0;
      sl0_q <= 1'b1;
      sl1_q <= 1'b1;
    end else begin
      state_q <= state_d;
      half_q <= half_d;
      bit_q <= bit_d;
      data_q <= data_d;
      len_q <= len_d;
      freq_q <= freq_d;
      sl0_q <= sl0_d;
      sl1_q <= sl1_d;
    end
  end
  always_comb begin
    rd_cfg = '0;
    rd_cfg[LEN_LSB+:LEN_W] = len_q;
    rd_cfg[FREQ_LSB+:FREQ_W] = freq_q;
    rd_cfg[BUSY_BIT] = busy;
`ifdef SL_TX_REMAIN_CNT_EN
    rd_cfg[REM_LSB+:6] = state_q == BIT ? 6'(bit_q) + 6'd2 : state_q == PARITY ? 6'd1 : 6'd0;
`endif
  end
  assign bus.d_out = bus.addr == ADDR_DATA ? data_q : rd_cfg;
  assign SL0 = sl0_q;
  assign SL1 = sl1_q;
endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: table-driven and sequence checks of sl_transmitter against a line-level receiver model
module tb_sl_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sl0, sl1;
  sl_transmitter_if bus ();
  sl_transmitter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .SL0(sl0),
    .SL1(sl1)
  );
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int rx_words = 0;
  logic [31:0] rx_word;
  int rx_bits;
  logic rx_par;
  int rx_lo_min, rx_lo_max;

  initial begin
    logic [63:0] sh;
    int n, lo_len, lo_min, lo_max;
    logic [1:0] prv, cur;
    sh = 0; n = 0; lo_len = 0; lo_min = 1000000; lo_max = 0; prv = 2'b11;
    forever begin
      @(negedge clk);
      cur = {sl1, sl0};
      if (rst) begin
        sh = 0; n = 0; lo_len = 0; lo_min = 1000000; lo_max = 0; prv = 2'b11;
      end else begin
        if (cur != 2'b11) lo_len++;
        else if (lo_len != 0) begin
          if (lo_len < lo_min) lo_min = lo_len;
          if (lo_len > lo_max) lo_max = lo_len;
          lo_len = 0;
          if (prv == 2'b00) begin
            rx_word = 32'(sh >> 1);
            rx_bits = n - 1;
            rx_par = ^sh;
            rx_lo_min = lo_min;
            rx_lo_max = lo_max;
            rx_words++;
            sh = 0; n = 0; lo_min = 1000000; lo_max = 0;
          end
        end
        if (prv == 2'b11 && cur == 2'b01) begin sh = {sh[62:0], 1'b1}; n++; end
        if (prv == 2'b11 && cur == 2'b10) begin sh = {sh[62:0], 1'b0}; n++; end
        prv = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.addr = a;
    bus.d_in = d;
    bus.wr_en = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.addr = 1'b1;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.d_out;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    bus.addr = 1'b1;
    #1;
    while (bus.d_out[16] && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20000) chk("busy_timeout", 1, 0);
  endtask

  typedef struct {
    logic [31:0] cfg_in;
    logic [31:0] data_in;
    logic [31:0] exp_cfg;
    logic [31:0] exp_data;
    int exp_busy;
    int exp_bits;
    int exp_h;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [31:0] v;
    int n, w0;
    vecs[0] = '{32'h0000_0008, 32'h0000_00A5, 32'h008, 32'h0000_00A5, 80, 8, 4};
    vecs[1] = '{32'h0000_02A0, 32'hFFFF_FFFF, 32'h2A0, 32'hFFFF_FFFF, 8704, 32, 128};
    vecs[2] = '{32'h0000_008A, 32'hFFFF_F2AB, 32'h08A, 32'h0000_02AB, 192, 10, 8};
    vecs[3] = '{32'h0000_010C, 32'hFFFF_FABC, 32'h10C, 32'h0000_0ABC, 448, 12, 16};
    vecs[4] = '{32'h0000_018E, 32'hF000_1234, 32'h18E, 32'h0000_1234, 1024, 14, 32};
    vecs[5] = '{32'h0000_0214, 32'hFF0F_00F1, 32'h214, 32'h000F_00F1, 2816, 20, 64};
    vecs[6] = '{32'h0000_03C8, 32'h0000_005A, 32'h288, 32'h0000_005A, 2560, 8, 128};
    vecs[7] = '{32'hFFFF_FC3F, 32'h8000_0001, 32'h020, 32'h8000_0001, 272, 32, 4};

    bus.d_in = '0;
    bus.wr_en = 1'b0;
    bus.addr = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_sl0", sl0, 1);
    chk("reset_sl1", sl1, 1);
    rd(1'b1, v);
    chk("reset_cfg", v, 32'h0000_0020);
    rd(1'b0, v);
    chk("reset_data", v, 0);

    for (int i = 0; i < 8; i++) begin
      wr(1'b1, vecs[i].cfg_in);
      rd(1'b1, v);
      chk($sformatf("v%0d_cfg", i), v, vecs[i].exp_cfg);
      w0 = rx_words;
      wr(1'b0, vecs[i].data_in);
      rd(1'b1, v);
      chk($sformatf("v%0d_busy_set", i), v[16], 1);
      wait_idle(n);
      chk($sformatf("v%0d_busy_len", i), n, vecs[i].exp_busy);
      rd(1'b0, v);
      chk($sformatf("v%0d_data_rd", i), v, vecs[i].exp_data);
      chk($sformatf("v%0d_words", i), rx_words, w0 + 1);
      chk($sformatf("v%0d_rx_word", i), rx_word, vecs[i].exp_data);
      chk($sformatf("v%0d_rx_bits", i), rx_bits, vecs[i].exp_bits);
      chk($sformatf("v%0d_parity", i), rx_par, 1);
      chk($sformatf("v%0d_lo_min", i), rx_lo_min, vecs[i].exp_h);
      chk($sformatf("v%0d_lo_max", i), rx_lo_max, vecs[i].exp_h);
    end

    wr(1'b1, 32'h008);
    w0 = rx_words;
    wr(1'b0, 32'hA5);
    repeat (79) @(posedge clk);
    #1;
    bus.addr = 1'b0;
    bus.d_in = 32'h77;
    bus.wr_en = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    rd(1'b0, v);
    chk("gap_exit_data", v, 32'hA5);
    rd(1'b1, v);
    chk("gap_exit_busy", v[16], 0);
    chk("gap_exit_words", rx_words, w0 + 1);

    wr(1'b1, 32'h000);
    rd(1'b1, v);
    chk("len0_cfg", v, 32'h000);
    wr(1'b0, 32'h55);
    rd(1'b1, v);
    chk("len0_busy", v[16], 0);
    rd(1'b0, v);
    chk("len0_data", v, 32'hA5);

    wr(1'b1, 32'h010);
    w0 = rx_words;
    wr(1'b0, 32'h1234);
    repeat (20) @(posedge clk);
    wr(1'b0, 32'hFFFF);
    wr(1'b1, 32'h188);
    rd(1'b1, v);
    chk("midword_cfg", v, 32'h0001_0010);
    rd(1'b0, v);
    chk("midword_data", v, 32'h1234);
    wait_idle(n);
    chk("midword_words", rx_words, w0 + 1);
    chk("midword_rx_word", rx_word, 32'h1234);
    chk("midword_rx_bits", rx_bits, 16);

    wr(1'b1, 32'h014);
    w0 = rx_words;
    wr(1'b0, 32'hABCDE);
    repeat (88) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sl0", sl0, 1);
    chk("rst_sl1", sl1, 1);
    rst = 1'b0;
    rd(1'b1, v);
    chk("rst_cfg", v, 32'h0000_0020);
    rd(1'b0, v);
    chk("rst_data", v, 0);
    repeat (200) @(posedge clk);
    #1;
    chk("rst_no_stop", rx_words, w0);
    chk("rst_idle_sl", {sl1, sl0}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
